// File: rtl/var_delay_line.sv
// Run-time selectable delay line for a data word and its valid strobe.
// Supports stall, flush and a configuration write guarded by occupancy.
module var_delay_line #(
    parameter int WIDTH     = 32,
    parameter int MAX_DEPTH = 32,
    parameter int DEPTH_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   i_reg,
    input  logic               srdyi_reg,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic               i_cfg_we,
    input  logic [DEPTH_W-1:0] i_cfg_delay,
    output logic [WIDTH-1:0]   o_reg,
    output logic               srdyo_reg,
    output logic               o_cfg_ack,
    output logic               o_cfg_err,
    output logic [DEPTH_W-1:0] o_delay,
    output logic               o_busy
);

    localparam logic [DEPTH_W:0] OCC_ONE = 1;

    logic [WIDTH-1:0]     r [MAX_DEPTH];
    logic [MAX_DEPTH-1:0] en;
    logic [MAX_DEPTH-1:0] win;
    logic [DEPTH_W-1:0]   dly;
    logic [DEPTH_W:0]     occ;
    logic                 acc;
    logic                 cfg_ok;

    assign acc       = srdyi_reg & ~i_stall & ~i_flush;
    assign o_reg     = r[dly];
    assign srdyo_reg = en[dly] & ~i_stall;
    assign o_busy    = (occ != '0);
    assign o_delay   = dly;
    assign cfg_ok    = i_cfg_we & (((occ == '0) & ~srdyi_reg) | i_flush);

    // Valids leaving the tap are dropped so nothing lingers past dly
    // and resurfaces after a later delay increase.
    always_comb begin
        win = '0;
        for (int k = 0; k < MAX_DEPTH; k++) begin
            win[k] = (DEPTH_W'(k) <= dly);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < MAX_DEPTH; k++) begin
                r[k] <= '0;
            end
        end else if (!i_stall) begin
            r[0] <= i_reg;
            for (int k = 1; k < MAX_DEPTH; k++) begin
                r[k] <= r[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en <= '0;
        end else if (i_flush) begin
            en <= '0;
        end else if (!i_stall) begin
            en <= {en[MAX_DEPTH-2:0] & win[MAX_DEPTH-1:1], acc};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= '0;
        end else if (i_flush) begin
            occ <= '0;
        end else if (acc & ~srdyo_reg) begin
            occ <= occ + OCC_ONE;
        end else if (~acc & srdyo_reg) begin
            occ <= occ - OCC_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly       <= DEPTH_W'(MAX_DEPTH - 1);
            o_cfg_ack <= 1'b0;
            o_cfg_err <= 1'b0;
        end else begin
            o_cfg_ack <= cfg_ok;
            o_cfg_err <= i_cfg_we & ~cfg_ok;
            if (cfg_ok) begin
                dly <= i_cfg_delay;
            end
        end
    end

endmodule

// File: tb/tb_var_delay_line.sv
// Directed bench for var_delay_line: latency, config guard, stall,
// flush and asynchronous reset.
module tb_var_delay_line;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] i_reg = '0;
    logic        srdyi_reg = 1'b0;
    logic        i_stall = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_cfg_we = 1'b0;
    logic [4:0]  i_cfg_delay = '0;
    logic [31:0] o_reg;
    logic        srdyo_reg;
    logic        o_cfg_ack;
    logic        o_cfg_err;
    logic [4:0]  o_delay;
    logic        o_busy;

    int tests = 0;
    int fails = 0;
    int n;
    int bad;

    var_delay_line dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_reg       (i_reg),
        .srdyi_reg   (srdyi_reg),
        .i_stall     (i_stall),
        .i_flush     (i_flush),
        .i_cfg_we    (i_cfg_we),
        .i_cfg_delay (i_cfg_delay),
        .o_reg       (o_reg),
        .srdyo_reg   (srdyo_reg),
        .o_cfg_ack   (o_cfg_ack),
        .o_cfg_err   (o_cfg_err),
        .o_delay     (o_delay),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [4:0] val);
        i_cfg_we    = 1'b1;
        i_cfg_delay = val;
        nxt();
        i_cfg_we    = 1'b0;
    endtask

    task automatic push(input logic [31:0] base, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            i_reg     = base + 32'(k);
            srdyi_reg = 1'b1;
            nxt();
        end
        srdyi_reg = 1'b0;
    endtask

    task automatic drain(input string tag, input int zeros, input int cnt,
                         input logic [31:0] base);
        chk({tag, "_pre"}, 32'(srdyo_reg), 32'd0);
        for (int k = 0; k < zeros; k++) begin
            nxt();
            chk($sformatf("%s_z%0d", tag, k), 32'(srdyo_reg), 32'd0);
        end
        for (int k = 0; k < cnt; k++) begin
            nxt();
            chk($sformatf("%s_v%0d", tag, k), 32'(srdyo_reg), 32'd1);
            chk($sformatf("%s_d%0d", tag, k), o_reg, base + 32'(k));
        end
        nxt();
        chk({tag, "_end"}, 32'(srdyo_reg), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_delay", 32'(o_delay), 32'd31);
        chk("rst_oreg", o_reg, 32'd0);
        chk("rst_srdyo", 32'(srdyo_reg), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_ack", 32'(o_cfg_ack), 32'd0);
        chk("rst_err", 32'(o_cfg_err), 32'd0);
        nxt();

        // Default delay of 32
        push(32'hA5A5_0001, 1);
        n = 1;
        bad = 0;
        while (srdyo_reg !== 1'b1 && n < 100) begin
            if (o_busy !== 1'b1) bad++;
            nxt();
            n++;
        end
        chk("d32_lat", 32'(n), 32'd32);
        chk("d32_busy", 32'(bad), 32'd0);
        chk("d32_busy_out", 32'(o_busy), 32'd1);
        chk("d32_data", o_reg, 32'hA5A5_0001);
        nxt();
        chk("d32_idle_srdyo", 32'(srdyo_reg), 32'd0);
        chk("d32_idle_busy", 32'(o_busy), 32'd0);

        // Delay 1
        cfg(5'd0);
        chk("d1_ack", 32'(o_cfg_ack), 32'd1);
        chk("d1_err", 32'(o_cfg_err), 32'd0);
        chk("d1_delay", 32'(o_delay), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            i_reg     = 32'(k);
            srdyi_reg = 1'b1;
            nxt();
            chk($sformatf("d1_v%0d", k), 32'(srdyo_reg), 32'd1);
            chk($sformatf("d1_d%0d", k), o_reg, 32'(k));
        end
        srdyi_reg = 1'b0;
        chk("d1_ack_pulse", 32'(o_cfg_ack), 32'd0);
        nxt();
        chk("d1_end", 32'(srdyo_reg), 32'd0);

        // Delay 7
        cfg(5'd6);
        chk("d7_ack", 32'(o_cfg_ack), 32'd1);
        chk("d7_delay", 32'(o_delay), 32'd6);
        push(32'd1, 4);
        drain("d7", 2, 4, 32'd1);

        // Guarded write rejected while samples are in flight
        cfg(5'd7);
        chk("d8_ack", 32'(o_cfg_ack), 32'd1);
        push(32'h31, 3);
        cfg(5'd2);
        chk("grd_err", 32'(o_cfg_err), 32'd1);
        chk("grd_ack", 32'(o_cfg_ack), 32'd0);
        chk("grd_delay", 32'(o_delay), 32'd7);
        drain("grd", 3, 3, 32'h31);

        // Stall at delay 4
        cfg(5'd3);
        chk("d4_ack", 32'(o_cfg_ack), 32'd1);
        push(32'h10, 1);
        chk("st_s0", 32'(srdyo_reg), 32'd0);
        nxt();
        chk("st_s1", 32'(srdyo_reg), 32'd0);
        i_stall   = 1'b1;
        srdyi_reg = 1'b1;
        i_reg     = 32'hBAD;
        #1;
        chk("st_hold0", 32'(srdyo_reg), 32'd0);
        bad = 0;
        repeat (5) begin
            nxt();
            if (srdyo_reg !== 1'b0) bad++;
        end
        chk("st_quiet", 32'(bad), 32'd0);
        i_stall   = 1'b0;
        srdyi_reg = 1'b0;
        nxt();
        chk("st_s8", 32'(srdyo_reg), 32'd0);
        nxt();
        chk("st_lat9", 32'(srdyo_reg), 32'd1);
        chk("st_data", o_reg, 32'h10);
        i_stall = 1'b1;
        #1;
        chk("st_mask", 32'(srdyo_reg), 32'd0);
        nxt();
        chk("st_mask2", 32'(srdyo_reg), 32'd0);
        chk("st_busy", 32'(o_busy), 32'd1);
        i_stall = 1'b0;
        #1;
        chk("st_resume", 32'(srdyo_reg), 32'd1);
        chk("st_resume_d", o_reg, 32'h10);
        nxt();
        chk("st_end", 32'(srdyo_reg), 32'd0);
        chk("st_end_busy", 32'(o_busy), 32'd0);

        // Flush together with a config write
        cfg(5'd7);
        chk("fl_cfg_ack", 32'(o_cfg_ack), 32'd1);
        push(32'h51, 5);
        chk("fl_busy_pre", 32'(o_busy), 32'd1);
        i_flush     = 1'b1;
        srdyi_reg   = 1'b1;
        i_reg       = 32'h99;
        i_cfg_we    = 1'b1;
        i_cfg_delay = 5'd15;
        nxt();
        i_flush   = 1'b0;
        srdyi_reg = 1'b0;
        i_cfg_we  = 1'b0;
        chk("fl_ack", 32'(o_cfg_ack), 32'd1);
        chk("fl_err", 32'(o_cfg_err), 32'd0);
        chk("fl_delay", 32'(o_delay), 32'd15);
        chk("fl_busy", 32'(o_busy), 32'd0);
        bad = 0;
        repeat (40) begin
            if (srdyo_reg !== 1'b0) bad++;
            nxt();
        end
        chk("fl_quiet", 32'(bad), 32'd0);

        // Asynchronous reset mid-stream at delay 16
        push(32'h61, 10);
        chk("ar_busy_pre", 32'(o_busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_srdyo", 32'(srdyo_reg), 32'd0);
        chk("ar_busy", 32'(o_busy), 32'd0);
        chk("ar_delay", 32'(o_delay), 32'd31);
        chk("ar_oreg", o_reg, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (40) begin
            nxt();
            if (srdyo_reg !== 1'b0) bad++;
        end
        chk("ar_quiet", 32'(bad), 32'd0);
        chk("ar_delay_end", 32'(o_delay), 32'd31);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
